// File: rtl/lab7soc_irq_collector_if.sv
// Avalon-MM register port of the IRQ collector: 16-bit data, 3-bit word address.
// Read data is registered by the slave and valid the cycle after address; no wait states.
interface lab7soc_irq_collector_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/lab7soc_irq_collector.sv
// Synchronizes raw IRQ lines, latches edge/level events into sticky pending bits and drives a masked,
// registered aggregate irq; register reads have 1-cycle latency and the slave never stalls.
module lab7soc_irq_collector #(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    lab7soc_irq_collector_if.slave     bus,
    input  logic [NUM_SRC-1:0]         src_irq,
    output logic                       irq
);

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_EDGE    = 3'd2;
    localparam logic [2:0] ADDR_OVERRUN = 3'd3;
    localparam logic [2:0] ADDR_RAW     = 3'd4;
    localparam logic [2:0] ADDR_FORCE   = 3'd5;

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] s;
    logic [NUM_SRC-1:0] prev;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] edge_mode;
    logic [NUM_SRC-1:0] overrun;

    logic               wr;
    logic [NUM_SRC-1:0] wdat;
    logic               wdat_unused;
    logic [NUM_SRC-1:0] edge_ev;
    logic [NUM_SRC-1:0] lvl_ev;
    logic [NUM_SRC-1:0] pend_set;
    logic [NUM_SRC-1:0] pend_clr;
    logic [NUM_SRC-1:0] ovr_set;
    logic [NUM_SRC-1:0] ovr_clr;
    logic [15:0]        rd_nxt;

    assign s           = sync_q[SYNC_STAGES-1];
    assign wr          = bus.chipselect & ~bus.write_n;
    assign wdat        = bus.writedata[NUM_SRC-1:0];
    assign wdat_unused = ^bus.writedata;

    assign edge_ev  = edge_mode & s & ~prev;
    assign lvl_ev   = ~edge_mode & s;
    assign pend_clr = (wr && bus.address == ADDR_PENDING) ? wdat : '0;
    assign pend_set = edge_ev | lvl_ev | ((wr && bus.address == ADDR_FORCE) ? wdat : '0);
    // A same-cycle W1C means software already saw the bit, so the repeat edge is not an overrun.
    assign ovr_set  = edge_ev & pending & ~pend_clr;
    assign ovr_clr  = (wr && bus.address == ADDR_OVERRUN) ? wdat : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= src_irq;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev      <= '0;
            pending   <= '0;
            overrun   <= '0;
            mask      <= '0;
            edge_mode <= '1;
        end else begin
            prev    <= s;
            pending <= pend_set | (pending & ~pend_clr);
            overrun <= ovr_set | (overrun & ~ovr_clr);
            if (wr && bus.address == ADDR_MASK) mask      <= wdat;
            if (wr && bus.address == ADDR_EDGE) edge_mode <= wdat;
        end
    end

    always_comb begin
        rd_nxt = '0;
        case (bus.address)
            ADDR_PENDING: rd_nxt[NUM_SRC-1:0] = pending;
            ADDR_MASK:    rd_nxt[NUM_SRC-1:0] = mask;
            ADDR_EDGE:    rd_nxt[NUM_SRC-1:0] = edge_mode;
            ADDR_OVERRUN: rd_nxt[NUM_SRC-1:0] = overrun;
            ADDR_RAW:     rd_nxt[NUM_SRC-1:0] = s;
            default:      rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            bus.readdata <= rd_nxt;
            irq          <= |(pending & mask);
        end
    end

endmodule

// File: tb/tb_lab7soc_irq_collector.sv
// Bench for lab7soc_irq_collector: directed register scenarios, then random traffic against a
// cycle-level reference model built from the register rules.
module tb_lab7soc_irq_collector;
    localparam int N  = 4;
    localparam int SS = 2;

    logic         clk;
    logic         rst;
    logic [N-1:0] src;
    logic         irq;

    int n_chk  = 0;
    int n_fail = 0;

    lab7soc_irq_collector_if bus ();

    lab7soc_irq_collector #(.NUM_SRC(N), .SYNC_STAGES(SS)) dut (
        .clk     (clk),
        .reset   (rst),
        .bus     (bus),
        .src_irq (src),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: s is the input as sampled SS clocks ago, held in a history queue.
    logic [N-1:0] m_q [$];
    logic [N-1:0] m_prev, m_pend, m_mask, m_edge, m_ovr;
    logic [N-1:0] m_s, m_wd, n_pend, n_ovr;
    logic [15:0]  m_rd;
    logic         m_irq, m_wr;
    logic [2:0]   m_a;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_prev = '0; m_pend = '0; m_mask = '0; m_edge = '1; m_ovr = '0;
            m_rd = '0; m_irq = 1'b0;
        end else begin
            m_s  = (m_q.size() >= SS) ? m_q[SS-1] : '0;
            m_wr = bus.chipselect && !bus.write_n;
            m_a  = bus.address;
            m_wd = bus.writedata[N-1:0];
            case (m_a)
                3'd0:    m_rd = 16'(m_pend);
                3'd1:    m_rd = 16'(m_mask);
                3'd2:    m_rd = 16'(m_edge);
                3'd3:    m_rd = 16'(m_ovr);
                3'd4:    m_rd = 16'(m_s);
                default: m_rd = 16'd0;
            endcase
            m_irq = (m_pend & m_mask) != 0;
            for (int b = 0; b < N; b++) begin
                bit rise, ev, w1c, frc, oclr;
                rise = m_edge[b] && m_s[b] && !m_prev[b];
                ev   = m_edge[b] ? rise : m_s[b];
                w1c  = m_wr && m_a == 3'd0 && m_wd[b];
                frc  = m_wr && m_a == 3'd5 && m_wd[b];
                oclr = m_wr && m_a == 3'd3 && m_wd[b];
                if (ev || frc)      n_pend[b] = 1'b1;
                else if (w1c)       n_pend[b] = 1'b0;
                else                n_pend[b] = m_pend[b];
                if (rise && m_pend[b] && !w1c) n_ovr[b] = 1'b1;
                else if (oclr)                 n_ovr[b] = 1'b0;
                else                           n_ovr[b] = m_ovr[b];
            end
            m_pend = n_pend;
            m_ovr  = n_ovr;
            if (m_wr && m_a == 3'd1) m_mask = m_wd;
            if (m_wr && m_a == 3'd2) m_edge = m_wd;
            m_prev = m_s;
            m_q.push_front(src);
            if (m_q.size() > SS) void'(m_q.pop_back());
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 16'd0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic reg_rd(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = a;
        @(negedge clk);
        d = bus.readdata;
        bus_idle();
    endtask

    task automatic pulse(input int b);
        src[b] = 1'b1;
        @(negedge clk);
        src[b] = 1'b0;
    endtask

    logic [15:0] rd;

    initial begin
        rst = 1'b1;
        src = '0;
        bus_idle();
        tick(3);
        rst = 1'b0;

        // Reset state
        reg_rd(3'd0, rd); check("rst_pending", rd, 16'h0000);
        reg_rd(3'd1, rd); check("rst_mask",    rd, 16'h0000);
        reg_rd(3'd2, rd); check("rst_edge",    rd, 16'h000F);
        reg_rd(3'd3, rd); check("rst_overrun", rd, 16'h0000);
        reg_rd(3'd4, rd); check("rst_raw",     rd, 16'h0000);
        check("rst_irq", irq, 1'b0);

        // Edge capture latency and W1C
        reg_wr(3'd1, 16'h0001);
        src[0] = 1'b1;
        @(negedge clk);
        src[0] = 1'b0;
        @(negedge clk); check("lat_irq_e1", irq, 1'b0);
        @(negedge clk); check("lat_irq_e2", irq, 1'b0);
        @(negedge clk); check("lat_irq_e3", irq, 1'b1);
        reg_rd(3'd0, rd); check("edge_pending", rd, 16'h0001);
        reg_wr(3'd0, 16'h0001); check("w1c_irq_hold", irq, 1'b1);
        tick(1);                check("w1c_irq_drop", irq, 1'b0);

        // Overrun on a second edge
        pulse(1); tick(4);
        pulse(1); tick(4);
        reg_rd(3'd0, rd); check("ovr_pending", rd, 16'h0002);
        reg_rd(3'd3, rd); check("ovr_set",     rd, 16'h0002);
        reg_wr(3'd3, 16'h0002);
        reg_rd(3'd3, rd); check("ovr_w1c",     rd, 16'h0000);
        reg_wr(3'd0, 16'h0002);
        reg_rd(3'd0, rd); check("ovr_pend_clr", rd, 16'h0000);

        // Level mode re-assert
        reg_wr(3'd2, 16'h0000);
        reg_wr(3'd1, 16'h0004);
        src[2] = 1'b1;
        tick(4);
        reg_rd(3'd0, rd); check("lvl_pending", rd, 16'h0004);
        reg_wr(3'd0, 16'h0004);
        reg_rd(3'd0, rd); check("lvl_reset_again", rd, 16'h0004);
        check("lvl_irq_stays", irq, 1'b1);
        src[2] = 1'b0;
        tick(4);
        reg_wr(3'd0, 16'h0004);
        reg_rd(3'd0, rd); check("lvl_cleared", rd, 16'h0000);
        check("lvl_irq_low", irq, 1'b0);
        reg_wr(3'd2, 16'h000F);
        reg_wr(3'd1, 16'h0000);

        // W1C colliding with an edge event: set wins, no overrun
        pulse(0); tick(4);
        src[0] = 1'b1;
        @(negedge clk);
        src[0] = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 3'd0; bus.writedata = 16'h0001;
        @(negedge clk);
        bus_idle();
        reg_rd(3'd0, rd); check("coll_pending", rd, 16'h0001);
        reg_rd(3'd3, rd); check("coll_overrun", rd, 16'h0000);
        reg_wr(3'd0, 16'h0001);

        // Force, mask gating, async reset
        reg_wr(3'd5, 16'h0008);
        reg_rd(3'd0, rd); check("force_pending", rd, 16'h0008);
        check("force_irq_masked", irq, 1'b0);
        reg_rd(3'd5, rd); check("force_reads0", rd, 16'h0000);
        reg_wr(3'd1, 16'h0008); check("mask_irq_c1", irq, 1'b0);
        tick(1);                check("mask_irq_c2", irq, 1'b1);
        tick(1);                check("pre_rst_rd", bus.readdata, 16'h0008);
        rst = 1'b1;
        #1;
        check("arst_irq", irq, 1'b0);
        check("arst_rd",  bus.readdata, 16'h0000);
        tick(2);
        rst = 1'b0;
        reg_rd(3'd0, rd); check("post_rst_pending", rd, 16'h0000);
        reg_rd(3'd2, rd); check("post_rst_edge",    rd, 16'h000F);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            check("rand_rd",  bus.readdata, m_rd);
            check("rand_irq", irq, m_irq);
            if ($urandom_range(3) == 0) src = N'($urandom);
            bus.chipselect = ($urandom_range(1) == 1);
            bus.write_n    = ($urandom_range(3) != 0);
            bus.address    = 3'($urandom_range(7));
            bus.writedata  = 16'($urandom);
            rst            = ($urandom_range(499) == 0);
        end
        @(negedge clk);
        check("rand_rd_last",  bus.readdata, m_rd);
        check("rand_irq_last", irq, m_irq);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
